// File: rtl/bus_interface_xl.sv
// Host bus front end: syncs async 8-bit bus, filters CS, strobes writes/reads, pairs bytes into words.
// Strobes land 1 clk after CS qualifies; the host is held off by DTACK until a read completes or times out.
package xv;
    localparam logic DTACK_ACK = 1'b0;
    localparam logic DTACK_NAK = 1'b1;
endpackage

module bus_interface_xl #(
    parameter int SYNC_STAGES = 2,
    parameter int CS_FILTER   = 1,
    parameter int REG_BITS    = 4,
    parameter int RD_TIMEOUT  = 15
) (
    input  logic                clk,
    input  logic                reset_n_i,
    input  logic                bus_cs_n_i,
    input  logic                bus_rd_nwr_i,
    input  logic [REG_BITS-1:0] bus_reg_num_i,
    input  logic                bus_bytesel_i,
    input  logic [7:0]          bus_data_i,
    output logic [7:0]          bus_data_o,
    output logic                bus_dtack_o,
    output logic                write_strobe_o,
    output logic                read_strobe_o,
    output logic                word_strobe_o,
    output logic [REG_BITS-1:0] reg_num_o,
    output logic                bytesel_o,
    output logic [7:0]          bytedata_o,
    output logic [15:0]         worddata_o,
    input  logic [15:0]         rd_data_i,
    input  logic                rd_ack_i,
    input  logic                timeout_clr_i,
    output logic                timeout_o
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RD_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK     = 2'd2;
    localparam int CNT_W = $clog2(RD_TIMEOUT + 1);
    localparam int FLT_W = $clog2(CS_FILTER + 1);

    logic [SYNC_STAGES:0]                   r_cs_sync;
    logic [SYNC_STAGES-1:0]                 r_rd_sync;
    logic [SYNC_STAGES-1:0]                 r_bs_sync;
    logic [SYNC_STAGES-1:0][REG_BITS-1:0]   r_reg_sync;
    logic [SYNC_STAGES-1:0][7:0]            r_dat_sync;
    logic [FLT_W-1:0]                       r_flt_cnt;
    logic                                   r_cs_filt;
    logic [1:0]                             r_state;
    logic [CNT_W-1:0]                       r_rd_cnt;
    logic                                   r_pend_vld;
    logic [7:0]                             r_pend_dat;
    logic [REG_BITS-1:0]                    r_pend_reg;
    logic [7:0]                             r_bus_data;
    logic                                   r_dtack;
    logic                                   r_wr_stb;
    logic                                   r_rd_stb;
    logic                                   r_word_stb;
    logic [REG_BITS-1:0]                    r_reg_num;
    logic                                   r_bytesel;
    logic [7:0]                             r_bytedata;
    logic [15:0]                            r_worddata;
    logic                                   r_timeout;

    logic                w_cs_en;
    logic                w_qualify;
    logic                w_rd_s;
    logic                w_bs_s;
    logic [REG_BITS-1:0] w_reg_s;
    logic [7:0]          w_dat_s;

    // CS runs one stage deeper so the data inputs are settled when it qualifies
    assign w_cs_en   = (r_cs_sync[SYNC_STAGES] == 1'b0);
    assign w_rd_s    = r_rd_sync[SYNC_STAGES-1];
    assign w_bs_s    = r_bs_sync[SYNC_STAGES-1];
    assign w_reg_s   = r_reg_sync[SYNC_STAGES-1];
    assign w_dat_s   = r_dat_sync[SYNC_STAGES-1];
    assign w_qualify = w_cs_en && !r_cs_filt && (r_flt_cnt == FLT_W'(CS_FILTER - 1));

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_cs_sync  <= '1;
            r_rd_sync  <= '0;
            r_bs_sync  <= '0;
            r_reg_sync <= '0;
            r_dat_sync <= '0;
            r_flt_cnt  <= '0;
            r_cs_filt  <= 1'b0;
        end else begin
            r_cs_sync  <= {r_cs_sync[SYNC_STAGES-1:0], bus_cs_n_i};
            r_rd_sync  <= {r_rd_sync[SYNC_STAGES-2:0], bus_rd_nwr_i};
            r_bs_sync  <= {r_bs_sync[SYNC_STAGES-2:0], bus_bytesel_i};
            r_reg_sync <= {r_reg_sync[SYNC_STAGES-2:0], bus_reg_num_i};
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], bus_data_i};
            if (!w_cs_en) begin
                r_flt_cnt <= '0;
                r_cs_filt <= 1'b0;
            end else if (!r_cs_filt) begin
                if (w_qualify) r_cs_filt <= 1'b1;
                else           r_flt_cnt <= r_flt_cnt + FLT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state    <= ST_IDLE;
            r_rd_cnt   <= '0;
            r_pend_vld <= 1'b0;
            r_pend_dat <= '0;
            r_pend_reg <= '0;
            r_bus_data <= '0;
            r_dtack    <= xv::DTACK_NAK;
            r_wr_stb   <= 1'b0;
            r_rd_stb   <= 1'b0;
            r_word_stb <= 1'b0;
            r_reg_num  <= '0;
            r_bytesel  <= 1'b0;
            r_bytedata <= '0;
            r_worddata <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_wr_stb   <= 1'b0;
            r_rd_stb   <= 1'b0;
            r_word_stb <= 1'b0;
            if (timeout_clr_i) r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_qualify) begin
                        r_reg_num  <= w_reg_s;
                        r_bytesel  <= w_bs_s;
                        r_bytedata <= w_dat_s;
                        if (w_rd_s) begin
                            r_rd_stb <= 1'b1;
                            r_rd_cnt <= '0;
                            r_state  <= ST_RD_WAIT;
                        end else begin
                            r_wr_stb <= 1'b1;
                            r_dtack  <= xv::DTACK_ACK;
                            r_state  <= ST_ACK;
                            if (!w_bs_s) begin
                                r_pend_vld <= 1'b1;
                                r_pend_dat <= w_dat_s;
                                r_pend_reg <= w_reg_s;
                            end else if (r_pend_vld && (r_pend_reg == w_reg_s)) begin
                                r_word_stb <= 1'b1;
                                r_worddata <= {r_pend_dat, w_dat_s};
                                r_pend_vld <= 1'b0;
                            end
                        end
                    end
                end
                ST_RD_WAIT: begin
                    // Ack is tested before the count so a same-cycle ack beats the timeout
                    if (!w_cs_en) begin
                        r_state <= ST_IDLE;
                    end else if (rd_ack_i) begin
                        r_bus_data <= r_bytesel ? rd_data_i[7:0] : rd_data_i[15:8];
                        r_dtack    <= xv::DTACK_ACK;
                        r_state    <= ST_ACK;
                    end else if (r_rd_cnt == CNT_W'(RD_TIMEOUT - 1)) begin
                        r_bus_data <= 8'hFF;
                        r_timeout  <= 1'b1;
                        r_dtack    <= xv::DTACK_ACK;
                        r_state    <= ST_ACK;
                    end else begin
                        r_rd_cnt <= r_rd_cnt + CNT_W'(1);
                    end
                end
                ST_ACK: begin
                    if (!w_cs_en) begin
                        r_dtack <= xv::DTACK_NAK;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus_data_o     = r_bus_data;
    assign bus_dtack_o    = r_dtack;
    assign write_strobe_o = r_wr_stb;
    assign read_strobe_o  = r_rd_stb;
    assign word_strobe_o  = r_word_stb;
    assign reg_num_o      = r_reg_num;
    assign bytesel_o      = r_bytesel;
    assign bytedata_o     = r_bytedata;
    assign worddata_o     = r_worddata;
    assign timeout_o      = r_timeout;
endmodule

// File: tb/tb_bus_interface_xl.sv
// Bench for bus_interface_xl: directed scenarios plus a randomized access mix against a transaction-level model.
module tb_bus_interface_xl;
    localparam int RB  = 4;
    localparam int TO  = 15;
    localparam int CSF = 3;

    logic          clk = 1'b0;
    logic          reset_n_i;
    logic          bus_cs_n_i;
    logic          bus_rd_nwr_i;
    logic [RB-1:0] bus_reg_num_i;
    logic          bus_bytesel_i;
    logic [7:0]    bus_data_i;
    logic [7:0]    bus_data_o;
    logic          bus_dtack_o;
    logic          write_strobe_o;
    logic          read_strobe_o;
    logic          word_strobe_o;
    logic [RB-1:0] reg_num_o;
    logic          bytesel_o;
    logic [7:0]    bytedata_o;
    logic [15:0]   worddata_o;
    logic [15:0]   rd_data_i;
    logic          rd_ack_i;
    logic          timeout_clr_i;
    logic          timeout_o;

    int total = 0;
    int bad   = 0;

    // Transaction-level model state
    bit            m_pend_vld;
    logic [7:0]    m_pend_dat;
    logic [RB-1:0] m_pend_reg;
    bit            m_tout;
    logic [7:0]    m_bus_data;

    // Results of the last access
    int            a_nwr, a_nrd, a_nword, a_misalign, a_lat;
    bit            a_ack, a_nak_ok;
    logic [15:0]   a_word;
    logic [RB-1:0] a_rn;
    logic [7:0]    a_bd, a_data;

    always #5 clk = ~clk;

    bus_interface_xl #(.SYNC_STAGES(2), .CS_FILTER(CSF), .REG_BITS(RB), .RD_TIMEOUT(TO)) dut (
        .clk(clk), .reset_n_i(reset_n_i), .bus_cs_n_i(bus_cs_n_i), .bus_rd_nwr_i(bus_rd_nwr_i),
        .bus_reg_num_i(bus_reg_num_i), .bus_bytesel_i(bus_bytesel_i), .bus_data_i(bus_data_i),
        .bus_data_o(bus_data_o), .bus_dtack_o(bus_dtack_o), .write_strobe_o(write_strobe_o),
        .read_strobe_o(read_strobe_o), .word_strobe_o(word_strobe_o), .reg_num_o(reg_num_o),
        .bytesel_o(bytesel_o), .bytedata_o(bytedata_o), .worddata_o(worddata_o),
        .rd_data_i(rd_data_i), .rd_ack_i(rd_ack_i), .timeout_clr_i(timeout_clr_i), .timeout_o(timeout_o)
    );

    // Model of a byte write: returns whether a word should complete and its value
    function automatic bit model_write(input logic [RB-1:0] rn, input bit bs, input logic [7:0] d,
                                       output logic [15:0] word);
        word = 16'h0;
        if (!bs) begin
            m_pend_vld = 1'b1; m_pend_dat = d; m_pend_reg = rn;
            return 1'b0;
        end
        if (m_pend_vld && m_pend_reg == rn) begin
            word = {m_pend_dat, d};
            m_pend_vld = 1'b0;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    // Drives one full bus cycle; ack_dly is clocks after the read strobe before rd_ack_i rises
    task automatic do_access(input bit rd, input logic [RB-1:0] rn, input bit bs, input logic [7:0] d,
                             input int ack_dly);
        bit got_stb = 1'b0;
        int since   = 0;
        a_nwr = 0; a_nrd = 0; a_nword = 0; a_misalign = 0; a_lat = -1;
        a_ack = 1'b0; a_nak_ok = 1'b0; a_word = 'x; a_rn = 'x; a_bd = 'x; a_data = 'x;
        bus_rd_nwr_i = rd; bus_reg_num_i = rn; bus_bytesel_i = bs; bus_data_i = d; rd_ack_i = 1'b0;
        repeat (3) @(negedge clk);
        bus_cs_n_i = 1'b0;
        for (int c = 0; c < 60 && !a_ack; c++) begin
            @(negedge clk);
            if (write_strobe_o) a_nwr++;
            if (read_strobe_o)  a_nrd++;
            if (word_strobe_o) begin
                a_nword++;
                a_word = worddata_o;
                if (!write_strobe_o) a_misalign++;
            end
            if (write_strobe_o || read_strobe_o) begin
                got_stb = 1'b1; since = 0; a_rn = reg_num_o; a_bd = bytedata_o;
            end else if (got_stb) begin
                since++;
            end
            if (bus_dtack_o == xv::DTACK_ACK) begin
                a_ack = 1'b1; a_lat = since; a_data = bus_data_o;
            end
            if (rd && got_stb && since == ack_dly) rd_ack_i = 1'b1;
        end
        rd_ack_i = 1'b0;
        bus_cs_n_i = 1'b1;
        for (int c = 0; c < 20 && !a_nak_ok; c++) begin
            @(negedge clk);
            if (write_strobe_o) a_nwr++;
            if (read_strobe_o)  a_nrd++;
            if (word_strobe_o)  a_nword++;
            if (bus_dtack_o == xv::DTACK_NAK) a_nak_ok = 1'b1;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic apply_reset();
        reset_n_i = 1'b0; bus_cs_n_i = 1'b1; bus_rd_nwr_i = 1'b0; bus_reg_num_i = '0;
        bus_bytesel_i = 1'b0; bus_data_i = '0; rd_data_i = '0; rd_ack_i = 1'b0; timeout_clr_i = 1'b0;
        m_pend_vld = 1'b0; m_tout = 1'b0; m_bus_data = 8'h00;
        repeat (3) @(negedge clk);
        reset_n_i = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if ({bus_data_o, bus_dtack_o, write_strobe_o, read_strobe_o, word_strobe_o, timeout_o} !==
            {8'h00, xv::DTACK_NAK, 4'b0000}) begin
            bad++;
            $display("FAIL reset_ctrl: got data=%h dtack=%b wr=%b rd=%b wd=%b to=%b, want 00/%b/0/0/0/0",
                     bus_data_o, bus_dtack_o, write_strobe_o, read_strobe_o, word_strobe_o, timeout_o,
                     xv::DTACK_NAK);
        end
        total++;
        if ({reg_num_o, bytesel_o, bytedata_o, worddata_o} !== '0) begin
            bad++;
            $display("FAIL reset_capture: got reg=%h bs=%b byte=%h word=%h, want all 0",
                     reg_num_o, bytesel_o, bytedata_o, worddata_o);
        end
    endtask

    task automatic test_word_pair();
        do_access(1'b0, 4'd3, 1'b0, 8'hAB, 0);
        total++;
        if (a_nwr !== 1 || a_nword !== 0 || a_lat !== 0 || !a_nak_ok || a_rn !== 4'd3 || a_bd !== 8'hAB) begin
            bad++;
            $display("FAIL pair_even: got wr=%0d word=%0d lat=%0d nak=%b reg=%h byte=%h, want 1/0/0/1/3/ab",
                     a_nwr, a_nword, a_lat, a_nak_ok, a_rn, a_bd);
        end
        do_access(1'b0, 4'd3, 1'b1, 8'hCD, 0);
        total++;
        if (a_nwr !== 1 || a_nword !== 1 || a_misalign !== 0 || a_word !== 16'hABCD || a_rn !== 4'd3 ||
            a_lat !== 0 || !a_nak_ok) begin
            bad++;
            $display("FAIL pair_odd: got wr=%0d word=%0d mis=%0d data=%h reg=%h lat=%0d nak=%b, want 1/1/0/abcd/3/0/1",
                     a_nwr, a_nword, a_misalign, a_word, a_rn, a_lat, a_nak_ok);
        end
    endtask

    task automatic test_reg_mismatch();
        do_access(1'b0, 4'd2, 1'b0, 8'h12, 0);
        do_access(1'b0, 4'd5, 1'b1, 8'h34, 0);
        total++;
        if (a_nwr !== 1 || a_nword !== 0) begin
            bad++;
            $display("FAIL mismatch_odd: got wr=%0d word=%0d, want 1/0", a_nwr, a_nword);
        end
        do_access(1'b0, 4'd2, 1'b1, 8'h56, 0);
        total++;
        if (a_nword !== 1 || a_word !== 16'h1256) begin
            bad++;
            $display("FAIL mismatch_late_odd: got word=%0d data=%h, want 1/1256", a_nword, a_word);
        end
    endtask

    task automatic test_read_ack();
        rd_data_i = 16'hBEEF;
        do_access(1'b1, 4'd7, 1'b1, 8'h00, 3);
        total++;
        if (a_nrd !== 1 || a_nwr !== 0 || a_data !== 8'hEF || a_lat !== 4 || timeout_o !== 1'b0 || !a_nak_ok) begin
            bad++;
            $display("FAIL read_ack: got rd=%0d wr=%0d data=%h lat=%0d to=%b nak=%b, want 1/0/ef/4/0/1",
                     a_nrd, a_nwr, a_data, a_lat, timeout_o, a_nak_ok);
        end
        m_bus_data = 8'hEF;
        // Ack arriving on the last waiting cycle must still beat the timeout
        rd_data_i = 16'h5AC3;
        do_access(1'b1, 4'd1, 1'b0, 8'h00, TO - 1);
        total++;
        if (a_data !== 8'h5A || a_lat !== TO || timeout_o !== 1'b0) begin
            bad++;
            $display("FAIL read_ack_boundary: got data=%h lat=%0d to=%b, want 5a/%0d/0", a_data, a_lat, timeout_o, TO);
        end
        m_bus_data = 8'h5A;
    endtask

    task automatic test_read_timeout();
        rd_data_i = 16'h1234;
        do_access(1'b1, 4'd4, 1'b1, 8'h00, 1000);
        total++;
        if (a_data !== 8'hFF || a_lat !== TO || timeout_o !== 1'b1 || !a_nak_ok) begin
            bad++;
            $display("FAIL read_timeout: got data=%h lat=%0d to=%b nak=%b, want ff/%0d/1/1",
                     a_data, a_lat, timeout_o, a_nak_ok, TO);
        end
        m_bus_data = 8'hFF;
        repeat (5) @(negedge clk);
        total++;
        if (timeout_o !== 1'b1) begin
            bad++;
            $display("FAIL timeout_sticky: got %b want 1", timeout_o);
        end
        timeout_clr_i = 1'b1;
        @(negedge clk);
        timeout_clr_i = 1'b0;
        @(negedge clk);
        total++;
        if (timeout_o !== 1'b0) begin
            bad++;
            $display("FAIL timeout_clear: got %b want 0", timeout_o);
        end
    endtask

    task automatic test_glitch();
        int n_stb  = 0;
        int n_dtk  = 0;
        bus_rd_nwr_i = 1'b0; bus_reg_num_i = 4'd6; bus_bytesel_i = 1'b0; bus_data_i = 8'h77;
        repeat (3) @(negedge clk);
        bus_cs_n_i = 1'b0;
        repeat (CSF - 1) @(negedge clk);
        bus_cs_n_i = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (write_strobe_o || read_strobe_o || word_strobe_o) n_stb++;
            if (bus_dtack_o !== xv::DTACK_NAK) n_dtk++;
        end
        total++;
        if (n_stb !== 0 || n_dtk !== 0) begin
            bad++;
            $display("FAIL cs_glitch: got strobes=%0d ack_cycles=%0d, want 0/0", n_stb, n_dtk);
        end
    endtask

    task automatic test_abort();
        int  n_dtk   = 0;
        bit  got_stb = 1'b0;
        rd_data_i = 16'h9966; bus_rd_nwr_i = 1'b1; bus_reg_num_i = 4'd1; bus_bytesel_i = 1'b1;
        repeat (3) @(negedge clk);
        bus_cs_n_i = 1'b0;
        for (int c = 0; c < 30 && !got_stb; c++) begin
            @(negedge clk);
            if (read_strobe_o) got_stb = 1'b1;
        end
        bus_cs_n_i = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus_dtack_o !== xv::DTACK_NAK) n_dtk++;
        end
        total++;
        if (!got_stb || n_dtk !== 0 || bus_data_o !== m_bus_data || timeout_o !== m_tout) begin
            bad++;
            $display("FAIL read_abort: got stb=%b ack_cycles=%0d data=%h to=%b, want 1/0/%h/%b",
                     got_stb, n_dtk, bus_data_o, timeout_o, m_bus_data, m_tout);
        end
    endtask

    task automatic test_reset_mid_read();
        bit got_stb = 1'b0;
        do_access(1'b0, 4'd9, 1'b0, 8'hC3, 0);
        bus_rd_nwr_i = 1'b1; bus_reg_num_i = 4'd9; bus_bytesel_i = 1'b1;
        repeat (3) @(negedge clk);
        bus_cs_n_i = 1'b0;
        for (int c = 0; c < 30 && !got_stb; c++) begin
            @(negedge clk);
            if (read_strobe_o) got_stb = 1'b1;
        end
        @(negedge clk);
        bus_cs_n_i = 1'b1;
        reset_n_i = 1'b0;
        #1;
        total++;
        if (!got_stb || {bus_data_o, bus_dtack_o, write_strobe_o, read_strobe_o, word_strobe_o, timeout_o,
                          reg_num_o, bytesel_o, bytedata_o, worddata_o} !==
                         {8'h00, xv::DTACK_NAK, 4'b0000, 4'h0, 1'b0, 8'h00, 16'h0000}) begin
            bad++;
            $display("FAIL reset_mid_read: got stb=%b data=%h dtack=%b reg=%h bs=%b byte=%h word=%h to=%b, want reset values",
                     got_stb, bus_data_o, bus_dtack_o, reg_num_o, bytesel_o, bytedata_o, worddata_o, timeout_o);
        end
        @(negedge clk);
        reset_n_i = 1'b1;
        m_pend_vld = 1'b0; m_tout = 1'b0; m_bus_data = 8'h00;
        @(negedge clk);
        do_access(1'b0, 4'd9, 1'b1, 8'h3C, 0);
        total++;
        if (a_nwr !== 1 || a_nword !== 0) begin
            bad++;
            $display("FAIL reset_drops_pending: got wr=%0d word=%0d, want 1/0", a_nwr, a_nword);
        end
    endtask

    task automatic test_random();
        bit            rd, bs, exp_wv;
        logic [RB-1:0] rn;
        logic [7:0]    d, exp_d;
        logic [15:0]   rdat, exp_w;
        int            dly, exp_lat;
        for (int i = 0; i < 40; i++) begin
            rd = ($urandom_range(0, 2) == 0);
            rn = RB'($urandom_range(0, 3));
            bs = 1'($urandom_range(0, 1));
            d  = 8'($urandom);
            if (rd) begin
                rdat = 16'($urandom);
                dly  = $urandom_range(0, 18);
                rd_data_i = rdat;
                do_access(1'b1, rn, bs, d, dly);
                if (dly <= TO - 1) begin
                    exp_d = bs ? rdat[7:0] : rdat[15:8];
                    exp_lat = dly + 1;
                end else begin
                    exp_d = 8'hFF;
                    exp_lat = TO;
                    m_tout = 1'b1;
                end
                m_bus_data = exp_d;
                total++;
                if (a_nrd !== 1 || a_nwr !== 0 || a_nword !== 0 || a_data !== exp_d || a_lat !== exp_lat ||
                    a_rn !== rn || timeout_o !== m_tout || !a_nak_ok) begin
                    bad++;
                    $display("FAIL rand_read[%0d]: got rd=%0d wr=%0d wd=%0d data=%h lat=%0d reg=%h to=%b nak=%b, want 1/0/0/%h/%0d/%h/%b/1",
                             i, a_nrd, a_nwr, a_nword, a_data, a_lat, a_rn, timeout_o, a_nak_ok,
                             exp_d, exp_lat, rn, m_tout);
                end
                if ($urandom_range(0, 1) == 1) begin
                    timeout_clr_i = 1'b1;
                    @(negedge clk);
                    timeout_clr_i = 1'b0;
                    m_tout = 1'b0;
                end
            end else begin
                exp_wv = model_write(rn, bs, d, exp_w);
                do_access(1'b0, rn, bs, d, 0);
                total++;
                if (a_nwr !== 1 || a_nrd !== 0 || a_nword !== int'(exp_wv) || a_misalign !== 0 ||
                    (exp_wv && a_word !== exp_w) || a_rn !== rn || a_bd !== d || a_lat !== 0 || !a_nak_ok) begin
                    bad++;
                    $display("FAIL rand_write[%0d]: got wr=%0d rd=%0d wd=%0d mis=%0d data=%h reg=%h byte=%h lat=%0d nak=%b, want 1/0/%0d/0/%h/%h/%h/0/1",
                             i, a_nwr, a_nrd, a_nword, a_misalign, a_word, a_rn, a_bd, a_lat, a_nak_ok,
                             exp_wv, exp_w, rn, d);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_word_pair();
        test_reg_mismatch();
        test_read_ack();
        test_read_timeout();
        test_glitch();
        test_abort();
        test_reset_mid_read();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
